pair_stream_unpacker: RTL and testbench



---
 rtl/pair_unpack_pkg.sv | 19 +
 rtl/pair_nest_counter.sv | 49 ++++
 rtl/pair_stream_unpacker.sv | 206 ++++++++++++++++++++
 tb/tb_pair_stream_unpacker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pair_unpack_pkg.sv
// pair_unpack_pkg
// Shared types and constants for the pair stream unpacker.
//   state_t     : controller states
//   PAIR_A_IDX  : field index of A (first element) inside a pair word, in DW units
//   PAIR_B_IDX  : field index of B (second element) inside a pair word, in DW units
package pair_unpack_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        FLUSH   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int PAIR_A_IDX = 0;
    localparam int PAIR_B_IDX = 1;

endpackage

// File: rtl/pair_nest_counter.sv
// pair_nest_counter
// Nested-for (i, j) iterator over the remaining pair schedule once the
// element count n is known. Walks (1,3),(1,4)..(1,n-1),(2,3)..(n-2,n-1).
// Ports:
//   clk, rst : clock, synchronous active-high reset (i=0, j=0)
//   n        : frozen element count (AW+1 bits)
//   load     : start the schedule at (1,3)
//   step     : advance to the next pair
//   i, j     : current expected pair indices
//   last     : current pair is the final one (n-2, n-1)
module pair_nest_counter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   n,
    input  logic          step,
    input  logic          load,
    output logic [AW-1:0] i,
    output logic [AW-1:0] j,
    output logic          last
);

    logic [AW:0] n_m1;
    logic [AW:0] n_m2;

    assign n_m1 = n - (AW+1)'(1);
    assign n_m2 = n - (AW+1)'(2);
    assign last = ({1'b0, i} == n_m2) && ({1'b0, j} == n_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            i <= '0;
            j <= '0;
        end else if (load) begin
            i <= AW'(1);
            j <= AW'(3);
        end else if (step) begin
            if ({1'b0, j} == n_m1) begin
                // next run starts right after the new i, i.e. old i + 2
                i <= i + AW'(1);
                j <= i + AW'(2);
            end else begin
                j <= j + AW'(1);
            end
        end
    end

endmodule

// File: rtl/pair_stream_unpacker.sv
// pair_stream_unpacker
// Rebuilds the element list A_0..A_{n-1} from a nested-for pair stream
// (0,1),(0,2)..(0,n-1),(1,2)..(n-2,n-1) and checks the tail of the stream.
// The first run (pairs with A == A_0) yields every element; the rest is
// only checked against the i/j schedule.
// Optional macro PAIR_UNPACK_CHECK_EN: keep the full element store and
// compare pair content in the check phase; without it only the pair count
// and protocol are checked.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   valid_in   : pair_in valid
//   pair_in    : [DW-1:0] = A, [2*DW-1:DW] = B
//   eos        : end of stream (applied after any pair in the same cycle)
//   dout       : reconstructed element (registered)
//   valid_out  : dout valid
//   count      : elements emitted so far
//   done       : stream closed, sticky until rst
//   err        : protocol/content error, sticky until rst
//
// state   | meaning
// IDLE    | waiting for first pair or empty-stream eos
// COLLECT | first run: each pair adds one element
// FLUSH   | emit last pending element, then close
// CHECK   | remaining runs, walked by the nested counter
// DONE    | closed; any further pair is an error
module pair_stream_unpacker
    import pair_unpack_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2*DW-1:0] pair_in,
    input  logic            eos,
    output logic [DW-1:0]   dout,
    output logic            valid_out,
    output logic [AW:0]     count,
    output logic            done,
    output logic            err
);

    localparam logic [AW:0] N_MAX = {1'b1, {AW{1'b0}}};

    state_t        state, state_nxt;
    logic [DW-1:0] pair_a, pair_b;
    logic [DW-1:0] first_a, pending;
    logic [AW:0]   n;
    logic [AW-1:0] ci, cj;
    logic          clast;
    logic          take_first, take_b, emit_pend, err_set;
    logic          cnt_load, cnt_step;
    logic          run2_bad, chk_bad;

    assign pair_a = pair_in[PAIR_A_IDX*DW +: DW];
    assign pair_b = pair_in[PAIR_B_IDX*DW +: DW];
    assign done   = (state == DONE);

    pair_nest_counter #(.AW(AW)) u_nest (
        .clk  (clk),
        .rst  (rst),
        .n    (n),
        .step (cnt_step),
        .load (cnt_load),
        .i    (ci),
        .j    (cj),
        .last (clast)
    );

`ifdef PAIR_UNPACK_CHECK_EN
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (take_first) begin
            mem[0] <= pair_a;
            mem[1] <= pair_b;
        end
        if (take_b) begin
            mem[n[AW-1:0]] <= pair_b;
        end
    end

    assign run2_bad = (pair_a != mem[1]) || (pair_b != mem[2]);
    assign chk_bad  = (pair_a != mem[ci]) || (pair_b != mem[cj]);
`else
    // indices only matter when content is compared
    logic idx_unused;
    assign idx_unused = ^{ci, cj};
    assign run2_bad   = 1'b0;
    assign chk_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        take_first = 1'b0;
        take_b     = 1'b0;
        emit_pend  = 1'b0;
        err_set    = 1'b0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    take_first = 1'b1;
                    state_nxt  = eos ? FLUSH : COLLECT;
                end else if (eos) begin
                    state_nxt = DONE;
                end
            end
            COLLECT: begin
                if (valid_in) begin
                    if (pair_a == first_a) begin
                        if (n == N_MAX) begin
                            err_set   = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            take_b    = 1'b1;
                            emit_pend = 1'b1;
                            if (eos) state_nxt = FLUSH;
                        end
                    end else begin
                        // first pair of run 1: element count is now final
                        emit_pend = 1'b1;
                        if (run2_bad) err_set = 1'b1;
                        if (n == (AW+1)'(3)) begin
                            state_nxt = DONE;
                        end else if (n == (AW+1)'(2) || eos) begin
                            err_set   = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            cnt_load  = 1'b1;
                            state_nxt = CHECK;
                        end
                    end
                end else if (eos) begin
                    emit_pend = 1'b1;
                    state_nxt = DONE;
                    if (n > (AW+1)'(2)) err_set = 1'b1;
                end
            end
            FLUSH: begin
                emit_pend = 1'b1;
                state_nxt = DONE;
                if (valid_in) err_set = 1'b1;
            end
            CHECK: begin
                if (valid_in) begin
                    cnt_step = 1'b1;
                    if (chk_bad) err_set = 1'b1;
                    if (clast) begin
                        state_nxt = DONE;
                    end else if (eos) begin
                        err_set   = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (eos) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (valid_in) err_set = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            valid_out <= 1'b0;
            count     <= '0;
            err       <= 1'b0;
            first_a   <= '0;
            pending   <= '0;
            n         <= '0;
        end else begin
            valid_out <= take_first | emit_pend;
            if (take_first) begin
                dout    <= pair_a;
                first_a <= pair_a;
                pending <= pair_b;
                n       <= (AW+1)'(2);
                count   <= count + (AW+1)'(1);
            end else if (emit_pend) begin
                dout  <= pending;
                count <= count + (AW+1)'(1);
            end
            if (take_b) begin
                pending <= pair_b;
                n       <= n + (AW+1)'(1);
            end
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pair_stream_unpacker.sv
module tb_pair_stream_unpacker;

    localparam int DW = 8;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_in = 1'b0;
    logic [2*DW-1:0] pair_in = '0;
    logic            eos = 1'b0;
    logic [DW-1:0]   dout;
    logic            valid_out;
    logic [AW:0]     count;
    logic            done;
    logic            err;

    int vectors = 0;
    int miscompares = 0;

    pair_stream_unpacker #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .pair_in   (pair_in),
        .eos       (eos),
        .dout      (dout),
        .valid_out (valid_out),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic e);
        valid_in = v;
        pair_in  = {b, a};
        eos      = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_elem(input string tag, input logic [DW-1:0] exp);
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(exp));
    endtask

    initial begin
        // reset state
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // four-element stream
        cyc(1'b1, 8'h11, 8'h22, 1'b0); chk_elem("s4_e0", 8'h11);
        cyc(1'b1, 8'h11, 8'h33, 1'b0); chk_elem("s4_e1", 8'h22);
        cyc(1'b1, 8'h11, 8'h44, 1'b0); chk_elem("s4_e2", 8'h33);
        cyc(1'b1, 8'h22, 8'h33, 1'b0); chk_elem("s4_e3", 8'h44);
        chk("s4_count", 32'(count), 32'd4);
        cyc(1'b1, 8'h22, 8'h44, 1'b0);
        chk("s4_p5_valid", 32'(valid_out), 32'd0);
        chk("s4_p5_done", 32'(done), 32'd0);
        cyc(1'b1, 8'h33, 8'h44, 1'b0);
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_err", 32'(err), 32'd0);
        chk("s4_p6_valid", 32'(valid_out), 32'd0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        chk("s4_done_sticky", 32'(done), 32'd1);
        chk("s4_count_final", 32'(count), 32'd4);

        // extra pair after done
        cyc(1'b1, 8'h55, 8'h66, 1'b0);
        chk("extra_err", 32'(err), 32'd1);
        chk("extra_valid", 32'(valid_out), 32'd0);
        chk("extra_done", 32'(done), 32'd1);

        // n = 2 with eos on the only pair
        do_reset();
        chk("n2_rst_err", 32'(err), 32'd0);
        chk("n2_rst_done", 32'(done), 32'd0);
        cyc(1'b1, 8'h05, 8'h06, 1'b1); chk_elem("n2_e0", 8'h05);
        chk("n2_done_early", 32'(done), 32'd0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0); chk_elem("n2_e1", 8'h06);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        chk("n2_done", 32'(done), 32'd1);
        chk("n2_count", 32'(count), 32'd2);
        chk("n2_err", 32'(err), 32'd0);
        chk("n2_valid_after", 32'(valid_out), 32'd0);

        // content mismatch in the check phase
        do_reset();
        cyc(1'b1, 8'h11, 8'h22, 1'b0); chk_elem("mm_e0", 8'h11);
        cyc(1'b1, 8'h11, 8'h33, 1'b0); chk_elem("mm_e1", 8'h22);
        cyc(1'b1, 8'h11, 8'h44, 1'b0); chk_elem("mm_e2", 8'h33);
        cyc(1'b1, 8'h22, 8'h33, 1'b0); chk_elem("mm_e3", 8'h44);
        chk("mm_err_pre", 32'(err), 32'd0);
        cyc(1'b1, 8'h22, 8'hB9, 1'b0);
`ifdef PAIR_UNPACK_CHECK_EN
        chk("mm_err", 32'(err), 32'd1);
`else
        chk("mm_err", 32'(err), 32'd0);
`endif
        chk("mm_done_early", 32'(done), 32'd0);
        cyc(1'b1, 8'h33, 8'h44, 1'b0);
        chk("mm_done", 32'(done), 32'd1);
        chk("mm_count", 32'(count), 32'd4);

        // early eos in the check phase
        do_reset();
        cyc(1'b1, 8'h11, 8'h22, 1'b0);
        cyc(1'b1, 8'h11, 8'h33, 1'b0);
        cyc(1'b1, 8'h11, 8'h44, 1'b0);
        cyc(1'b1, 8'h22, 8'h33, 1'b0);
        chk("ee_err_pre", 32'(err), 32'd0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1);
        chk("ee_err", 32'(err), 32'd1);
        chk("ee_done", 32'(done), 32'd1);

        // eos alone during the first run with n > 2
        do_reset();
        cyc(1'b1, 8'h11, 8'h22, 1'b0);
        cyc(1'b1, 8'h11, 8'h33, 1'b0);
        cyc(1'b0, 8'h00, 8'h00, 1'b1); chk_elem("ce_last", 8'h33);
        chk("ce_err", 32'(err), 32'd1);
        chk("ce_done", 32'(done), 32'd1);
        chk("ce_count", 32'(count), 32'd3);

        // reset mid-collect, then a three-element stream
        do_reset();
        cyc(1'b1, 8'h11, 8'h22, 1'b0);
        cyc(1'b1, 8'h11, 8'h33, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'h11, 8'h44, 1'b0);
        rst = 1'b0;
        chk("mr_dout", 32'(dout), 32'd0);
        chk("mr_valid", 32'(valid_out), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        cyc(1'b1, 8'hA1, 8'hB2, 1'b0); chk_elem("mr_e0", 8'hA1);
        cyc(1'b1, 8'hA1, 8'hC3, 1'b0); chk_elem("mr_e1", 8'hB2);
        cyc(1'b1, 8'hB2, 8'hC3, 1'b0); chk_elem("mr_e2", 8'hC3);
        chk("mr_count_final", 32'(count), 32'd3);
        chk("mr_done", 32'(done), 32'd1);
        chk("mr_err", 32'(err), 32'd0);

        cyc(1'b0, 8'h00, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
